// File: rtl/alu_64.sv
// Registered 64-bit integer ALU: pass-B, add, sub, and, or, xor with N/Z/V/C flags.
// Optional: define ALU_SHIFT_EN to make cntrl=111 a logical left shift; otherwise 111 yields 0.
module alu_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [2:0] OpPass = 3'b000;
    localparam logic [2:0] OpZero = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpAnd  = 3'b100;
    localparam logic [2:0] OpOr   = 3'b101;
    localparam logic [2:0] OpXor  = 3'b110;
    localparam logic [2:0] OpShl  = 3'b111;

    logic             is_sub;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum_ext;
    logic             carry_msb_in;
    logic             add_v;
    logic             add_c;

    logic [WIDTH-1:0] result_d;
    logic             negative_d;
    logic             zero_d;
    logic             overflow_d;
    logic             carry_out_d;

    // SUB shares the adder as A + ~B + 1; carry out then means "no borrow".
    assign is_sub       = (cntrl == OpSub);
    assign b_opnd       = is_sub ? ~B : B;
    assign sum_ext      = {1'b0, A} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    assign carry_msb_in = sum_ext[WIDTH-1] ^ A[WIDTH-1] ^ b_opnd[WIDTH-1];
    assign add_c        = sum_ext[WIDTH];
    assign add_v        = carry_msb_in ^ add_c;

    always_comb begin
        result_d    = '0;
        overflow_d  = 1'b0;
        carry_out_d = 1'b0;
        unique case (cntrl)
            OpPass: result_d = B;
            OpZero: result_d = '0;
            OpAdd, OpSub: begin
                result_d    = sum_ext[WIDTH-1:0];
                overflow_d  = add_v;
                carry_out_d = add_c;
            end
            OpAnd:  result_d = A & B;
            OpOr:   result_d = A | B;
            OpXor:  result_d = A ^ B;
            OpShl: begin
`ifdef ALU_SHIFT_EN
                result_d = A << B[ShW-1:0];
`else
                result_d = '0;
`endif
            end
        endcase
        negative_d = result_d[WIDTH-1];
        zero_d     = ~|result_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            result    <= result_d;
            negative  <= negative_d;
            zero      <= zero_d;
            overflow  <= overflow_d;
            carry_out <= carry_out_d;
        end
    end

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed vector table, random pass-B, reset corner cases.
// Expected results are queued when inputs are driven and popped one cycle later.
module tb_alu_64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    alu_64 dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int n_vec = 0;
    int n_miss = 0;

    task automatic add_vec(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] res,
                           input logic n, input logic z, input logic v, input logic c);
        vec_t t;
        t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
        t.n = n; t.z = z; t.v = v; t.c = c;
        vecs.push_back(t);
    endtask

    task automatic check(input vec_t e);
        n_vec++;
        if (result !== e.res || negative !== e.n || zero !== e.z ||
            overflow !== e.v || carry_out !== e.c) begin
            n_miss++;
            $display("FAIL %s: got res=%h N=%b Z=%b V=%b C=%b, want res=%h N=%b Z=%b V=%b C=%b",
                     e.name, result, negative, zero, overflow, carry_out,
                     e.res, e.n, e.z, e.v, e.c);
        end
    endtask

    // Drive on the falling edge, compare 1 ns after the following rising edge.
    task automatic apply(input vec_t t);
        vec_t e;
        @(negedge clk);
        A = t.a; B = t.b; cntrl = t.op;
        sb.push_back(t);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_empty: got no expectation, want one for %s", t.name);
        end else begin
            e = sb.pop_front();
            check(e);
        end
    endtask

    task automatic check_zero(input string name);
        vec_t z;
        z.name = name; z.op = 3'b000; z.a = '0; z.b = '0; z.res = '0;
        z.n = 0; z.z = 0; z.v = 0; z.c = 0;
        check(z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;

        add_vec("add_1p1",      3'b010, 64'd1, 64'd1, 64'd2, 0, 0, 0, 0);
        add_vec("add_smax",     3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                64'h8000_0000_0000_0000, 1, 0, 1, 0);
        add_vec("add_umax",     3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 1, 0, 1);
        add_vec("add_smin2",    3'b010, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'd0, 0, 1, 1, 1);
        add_vec("sub_5m2",      3'b011, 64'd5, 64'd2, 64'd3, 0, 0, 0, 1);
        add_vec("sub_2m5",      3'b011, 64'd2, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 0, 0);
        add_vec("sub_smin",     3'b011, 64'h8000_0000_0000_0000, 64'd1,
                64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
        add_vec("sub_0m0",      3'b011, 64'd0, 64'd0, 64'd0, 0, 1, 0, 1);
        add_vec("and",          3'b100, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F,
                64'h0F000F000F000F00, 0, 0, 0, 0);
        add_vec("or",           3'b101, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F,
                64'hFF0FFF0FFF0FFF0F, 1, 0, 0, 0);
        add_vec("xor",          3'b110, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F,
                64'hF00FF00FF00FF00F, 1, 0, 0, 0);
        add_vec("xor_self",     3'b110, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567,
                64'd0, 0, 1, 0, 0);
        add_vec("zero_op",      3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 0, 1, 0, 0);
        add_vec("passb_zero",   3'b000, 64'h1234, 64'd0, 64'd0, 0, 1, 0, 0);
        add_vec("passb_neg",    3'b000, 64'd0, 64'h8000_0000_0000_0001,
                64'h8000_0000_0000_0001, 1, 0, 0, 0);
`ifdef ALU_SHIFT_EN
        add_vec("shl_1_63",     3'b111, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1, 0, 0, 0);
        add_vec("shl_1_mask",   3'b111, 64'd1, 64'h43, 64'd8, 0, 0, 0, 0);
`else
        add_vec("op7_1_63",     3'b111, 64'd1, 64'd63, 64'd0, 0, 1, 0, 0);
        add_vec("op7_1_mask",   3'b111, 64'd1, 64'h43, 64'd0, 0, 1, 0, 0);
`endif
        for (int i = 0; i < 10; i++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) rb[63] = 1'b1;
            add_vec($sformatf("passb_rand%0d", i), 3'b000, ra, rb, rb, rb[63], rb == 0, 0, 0);
        end

        // Power-on reset, including a clock edge with live inputs.
        reset = 1'b1; A = 64'd7; B = 64'd9; cntrl = 3'b010;
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset_initial");

        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-run must clear outputs immediately and discard in-flight work.
        t.name = "pre_reset"; t.op = 3'b010; t.a = 64'h7FFF_FFFF_FFFF_FFFF; t.b = 64'd1;
        t.res = 64'h8000_0000_0000_0000; t.n = 1; t.z = 0; t.v = 1; t.c = 0;
        apply(t);
        @(negedge clk);
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; cntrl = 3'b010;
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_async");
        @(posedge clk); #1;
        check_zero("reset_held");

        @(negedge clk);
        reset = 1'b0;
        t.name = "post_reset_add"; t.op = 3'b010; t.a = 64'd1; t.b = 64'd1;
        t.res = 64'd2; t.n = 0; t.z = 0; t.v = 0; t.c = 0;
        A = t.a; B = t.b; cntrl = t.op;
        sb.push_back(t);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_empty: got no expectation, want post_reset_add");
        end else begin
            t = sb.pop_front();
            check(t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
